uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single transmit path of one `Uart` instance among `NUM_CLIENTS` byte-stream requesters. Grants are round-robin and frame-locked: the granted client keeps the transmitter until it sends a byte flagged `last`. The arbiter drives the UART's `write_i`/`data_i` and sequences each byte against its `write_busy_o`. It sits between the command/telemetry producers and the `Uart` wrapper.

## Interface
- `NUM_CLIENTS`, 4 — number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 1024 — idle-valid cycles before a held grant is revoked; used only with the timeout feature compiled in.

- `clock_i`  in  1  — single clock; all logic is on its rising edge.
- `reset_i`  in  1  — asynchronous, active-low reset.
- `req_valid_i`  in  NUM_CLIENTS  — per-client byte valid.
- `req_data_i`  in  8*NUM_CLIENTS  — per-client byte; client k uses bits [8k+7:8k].
- `req_last_i`  in  NUM_CLIENTS  — per-client flag marking the byte as the final byte of its frame.
- `req_ready_o`  out  NUM_CLIENTS  — per-client accept; a byte transfers when valid and ready are both high.
- `grant_o`  out  NUM_CLIENTS  — one-hot current owner; all zero when no client owns the transmitter.
- `uart_write_o`  out  1  — one-cycle write strobe to the UART `write_i`.
- `uart_data_o`  out  8  — byte to the UART `data_i`.
- `uart_busy_i`  in  1  — from the UART `write_busy_o`.
- `timeout_o`  out  1  — one-cycle pulse when a grant is revoked by timeout.

## Operation
- **States:** IDLE, SEND, WRITE, WAIT_START, WAIT_DONE.
- **IDLE**
  - `grant_o` is 0.
  - If any `req_valid_i` is high and `uart_busy_i` is 0, select the first valid client at or after `ptr`, searching upward with wrap.
  - Register its one-hot grant and go to SEND.
- **SEND**
  - `req_ready_o[k] = grant_o[k] & ~uart_busy_i`, combinational from registered state.
  - On transfer: latch the byte into `uart_data_o`, latch `last` into `frame_end`, and go to WRITE.
- **WRITE**
  - `uart_write_o` is 1 for exactly this cycle, then go to WAIT_START.
- **WAIT_START**
  - Wait for `uart_busy_i` to be 1, then go to WAIT_DONE.
  - If `uart_busy_i` has not risen after 2 cycles, go to WAIT_DONE anyway.
- **WAIT_DONE**
  - Wait for `uart_busy_i` to be 0.
  - If `frame_end` is 1: clear the grant, set `ptr` to the granted index + 1 (mod NUM_CLIENTS), and go to IDLE.
  - Otherwise return to SEND with the grant held.
- **Client rules**
  - A client must not drop `req_valid_i` or change its data before ready.
  - Non-granted clients see ready 0.
- **Pointer arithmetic:** `ptr` is $clog2(NUM_CLIENTS) bits and wraps from NUM_CLIENTS-1 to 0.
- **Reset**
  - Async assertion forces IDLE at any time, including mid-byte or mid-frame, with `ptr` = 0 (client 0 has highest priority).
  - All outputs reset to 0.
  - After release, no grant is issued until `uart_busy_i` is 0.

## Timing
- Request to grant: 1 cycle (valid sampled in IDLE at T, `grant_o` high at T+1).
- Transfer at cycle T → `uart_write_o` high at T+1 → UART busy expected high at T+2.
- Minimum per-byte overhead beyond the UART frame time: 3 cycles (SEND, WRITE, plus the WAIT_DONE exit).
- Back-to-back frames from different clients: the next grant is issued 1 cycle after `frame_end` release (the IDLE cycle).
- Simultaneous requests are resolved by `ptr` only. Request arrival order is ignored.
- `timeout_o` and the grant release occur in the same cycle.

## Configuration
- **Macro:** `UART_TX_ARB_TIMEOUT_EN`.
- **Defined**
  - In SEND, a counter increments every cycle in which the granted client's `req_valid_i` is 0, and clears when it is 1.
  - When the count reaches TIMEOUT_CYCLES-1: pulse `timeout_o`, release the grant, advance `ptr` past that client, and go to IDLE.
- **Undefined**
  - No counter is built.
  - The grant is held indefinitely until a `last` byte is sent.
  - `timeout_o` is tied to 0.

## Test plan
- **Single frame:** Client 2 sends 0x41, 0x42 (last on 0x42), busy modelled 10 cycles per byte → `uart_write_o` pulses exactly twice with data 0x41 then 0x42, `grant_o` = 0100 throughout, then 0.
- **Round-robin:** All 4 clients hold single-byte frames 0x10..0x13 from reset → transmit order is 0,1,2,3. Repeat with `ptr` = 2 → order is 2,3,0,1.
- **Frame lock:** Client 0 sends a 3-byte frame while client 1 requests → client 1 sees ready 0 until after client 0's last byte, then is granted 1 cycle later.
- **Reset mid-frame:** Assert `reset_i` low during WAIT_DONE → all outputs 0 asynchronously. After release with busy held 1, no grant until busy falls.
- **Busy never rises:** Hold `uart_busy_i` = 0 → each byte completes via the 2-cycle WAIT_START guard with no hang.
- **Timeout (`UART_TX_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES = 16):** Client 1 sends a non-last byte, then drops valid → `timeout_o` pulses 16 cycles into SEND, and waiting client 2 is granted the next cycle.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Client byte-stream requests plus the UART write/busy handshake for uart_tx_arbiter.
// master = requesters and UART side, slave = the arbiter.
interface uart_tx_arbiter_if #(
   parameter int unsigned NUM_CLIENTS = 4
);
   logic [NUM_CLIENTS-1:0]   req_valid;
   logic [8*NUM_CLIENTS-1:0] req_data;
   logic [NUM_CLIENTS-1:0]   req_last;
   logic [NUM_CLIENTS-1:0]   req_ready;
   logic [NUM_CLIENTS-1:0]   grant;
   logic                     uart_write;
   logic [7:0]               uart_data;
   logic                     uart_busy;
   logic                     timeout;

   modport master (
      output req_valid, req_data, req_last, uart_busy,
      input  req_ready, grant, uart_write, uart_data, timeout
   );

   modport slave (
      input  req_valid, req_data, req_last, uart_busy,
      output req_ready, grant, uart_write, uart_data, timeout
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-locked arbiter sharing one UART transmitter among NUM_CLIENTS requesters.
// Optional idle-grant revocation is compiled in with `define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int unsigned NUM_CLIENTS    = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input logic              clock_i,
   input logic              reset_i,
   uart_tx_arbiter_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(NUM_CLIENTS);

   if (NUM_CLIENTS < 2 || NUM_CLIENTS > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("uart_tx_arbiter: NUM_CLIENTS must be 2..8 and TIMEOUT_CYCLES at least 2");
   end

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      WRITE,
      WAIT_START,
      WAIT_DONE
   } state_t;

   state_t                 state;
   logic [PTR_W-1:0]       ptr;
   logic [PTR_W-1:0]       owner;
   logic [NUM_CLIENTS-1:0] grant;
   logic                   uart_write;
   logic [7:0]             uart_data;
   logic                   frame_end;
   logic                   start_wait;
   logic                   pick_hit;
   logic [PTR_W-1:0]       pick_idx;
   logic                   owner_valid;

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   logic [TMO_W-1:0] idle_cnt;
   logic             timeout;
`endif

   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                 input int unsigned offset);
      return PTR_W'((32'(base) + offset) % NUM_CLIENTS);
   endfunction

   // First valid client at or after ptr, searching upward with wrap.
   always_comb begin
      pick_hit = 1'b0;
      pick_idx = ptr;
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
         if (!pick_hit && bus.req_valid[wrap_add(ptr, i)]) begin
            pick_hit = 1'b1;
            pick_idx = wrap_add(ptr, i);
         end
      end
   end

   assign owner_valid   = bus.req_valid[owner];
   assign bus.req_ready = (state == SEND && !bus.uart_busy) ? grant : '0;
   assign bus.grant      = grant;
   assign bus.uart_write = uart_write;
   assign bus.uart_data  = uart_data;
`ifdef UART_TX_ARB_TIMEOUT_EN
   assign bus.timeout    = timeout;
`else
   assign bus.timeout    = 1'b0;
`endif

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state      <= IDLE;
         ptr        <= '0;
         owner      <= '0;
         grant      <= '0;
         uart_write <= 1'b0;
         uart_data  <= '0;
         frame_end  <= 1'b0;
         start_wait <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
         idle_cnt   <= '0;
         timeout    <= 1'b0;
`endif
      end else begin
         uart_write <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
         timeout    <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (pick_hit && !bus.uart_busy) begin
                  owner <= pick_idx;
                  grant <= NUM_CLIENTS'(1) << pick_idx;
                  state <= SEND;
`ifdef UART_TX_ARB_TIMEOUT_EN
                  idle_cnt <= '0;
`endif
               end
            end

            SEND: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
               // Counts consecutive cycles the owner leaves its valid low.
               if (owner_valid) begin
                  idle_cnt <= '0;
               end else if (idle_cnt != TMO_LAST) begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
`endif
               if (owner_valid && !bus.uart_busy) begin
                  uart_data  <= bus.req_data[{owner, 3'b000} +: 8];
                  frame_end  <= bus.req_last[owner];
                  uart_write <= 1'b1;
                  state      <= WRITE;
               end
`ifdef UART_TX_ARB_TIMEOUT_EN
               else if (!owner_valid && idle_cnt == TMO_LAST) begin
                  timeout <= 1'b1;
                  grant   <= '0;
                  ptr     <= wrap_add(owner, 1);
                  state   <= IDLE;
               end
`endif
            end

            WRITE: begin
               start_wait <= 1'b0;
               state      <= WAIT_START;
            end

            // Give the UART two cycles to raise busy so a missing busy cannot hang us.
            WAIT_START: begin
               if (bus.uart_busy || start_wait) begin
                  state <= WAIT_DONE;
               end else begin
                  start_wait <= 1'b1;
               end
            end

            WAIT_DONE: begin
               if (!bus.uart_busy) begin
                  if (frame_end) begin
                     grant <= '0;
                     ptr   <= wrap_add(owner, 1);
                     state <= IDLE;
                  end else begin
                     state <= SEND;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter: a frame-level round-robin model
// predicts the byte/owner order written to a behavioural UART busy model.
module tb_uart_tx_arbiter;
   localparam int NC = 4;
`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 1024;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_CLIENTS(NC)) bus ();

   uart_tx_arbiter #(.NUM_CLIENTS(NC), .TIMEOUT_CYCLES(TMO)) dut (
      .clock_i(clk),
      .reset_i(rst_n),
      .bus    (bus)
   );

   int vectors;
   int miscompares;

   logic [8:0]    cq [NC][$];   // per-client pending bytes, bit 8 = last
   int            model_ptr;
   int            busy_left;
   int            busy_len;
   logic [7:0]    exp_data[$];
   int            exp_own[$];
   logic [7:0]    got_data[$];
   int            got_own[$];
   int            got_cyc[$];
   int            gt_cyc[$];
   logic [NC-1:0] gt_val[$];
   int            tmo_cyc[$];

   function automatic int onehot_index(input logic [NC-1:0] v);
      int idx = -1;
      int n = 0;
      for (int i = 0; i < NC; i++) if (v[i]) begin idx = i; n++; end
      return (n == 1) ? idx : -1;
   endfunction

   function automatic bit all_empty();
      for (int c = 0; c < NC; c++) if (cq[c].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drive_clients();
      for (int c = 0; c < NC; c++) begin
         if (cq[c].size() > 0) begin
            bus.req_valid[c]        = 1'b1;
            bus.req_data[8*c +: 8]  = cq[c][0][7:0];
            bus.req_last[c]         = cq[c][0][8];
         end else begin
            bus.req_valid[c]        = 1'b0;
            bus.req_data[8*c +: 8]  = 8'h00;
            bus.req_last[c]         = 1'b0;
         end
      end
      bus.uart_busy = (busy_left > 0);
   endtask

   // Whole frames go out in round-robin order starting at model_ptr.
   task automatic build_model();
      int pos [NC];
      int pick;
      logic [8:0] e;
      exp_data.delete();
      exp_own.delete();
      for (int c = 0; c < NC; c++) pos[c] = 0;
      while (1) begin
         pick = -1;
         for (int k = 0; k < NC; k++)
            if (pick < 0 && pos[(model_ptr + k) % NC] < cq[(model_ptr + k) % NC].size())
               pick = (model_ptr + k) % NC;
         if (pick < 0) break;
         do begin
            e = cq[pick][pos[pick]];
            pos[pick]++;
            exp_data.push_back(e[7:0]);
            exp_own.push_back(pick);
         end while (!e[8] && pos[pick] < cq[pick].size());
         model_ptr = (pick + 1) % NC;
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      for (int c = 0; c < NC; c++) cq[c].delete();
      busy_left = 0;
      busy_len  = 0;
      drive_clients();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_ptr = 0;
   endtask

   task automatic run(input int budget, input bit check);
      logic [NC-1:0] prev_grant;
      logic [NC-1:0] fire;
      bit wrote, prev_write, done;
      int own, n;
      if (check) build_model();
      got_data.delete(); got_own.delete(); got_cyc.delete();
      gt_cyc.delete(); gt_val.delete(); tmo_cyc.delete();
      prev_grant = '0;
      prev_write = 1'b0;
      done = 1'b0;
      drive_clients();
      for (int cyc = 0; !done; cyc++) begin
         @(negedge clk);
         own = onehot_index(bus.grant);
         vectors++;
         if ((bus.grant != '0 && own < 0) || ((bus.req_ready & ~bus.grant) != '0)) begin
            miscompares++;
            $display("FAIL grant_ready cycle %0d: grant=%b ready=%b, required one-hot grant and ready only for owner",
                     cyc, bus.grant, bus.req_ready);
         end
         wrote = bus.uart_write;
         if (wrote) begin
            vectors++;
            if (prev_write || own < 0) begin
               miscompares++;
               $display("FAIL write_strobe cycle %0d: prev_write=%0b owner=%0d, required single pulse with an owner",
                        cyc, prev_write, own);
            end
            got_data.push_back(bus.uart_data);
            got_own.push_back(own);
            got_cyc.push_back(cyc);
         end
         if (bus.grant != prev_grant) begin
            gt_cyc.push_back(cyc);
            gt_val.push_back(bus.grant);
         end
         if (bus.timeout) tmo_cyc.push_back(cyc);
         fire       = bus.req_valid & bus.req_ready;
         prev_grant = bus.grant;
         prev_write = wrote;
         if (all_empty() && bus.grant == '0) begin
            done = 1'b1;
         end else if (cyc >= budget) begin
            done = 1'b1;
            if (check) begin
               vectors++;
               miscompares++;
               $display("FAIL run_budget: traffic still pending after %0d cycles, required drain", budget);
            end
         end else begin
            @(posedge clk);
            #1;
            for (int c = 0; c < NC; c++) if (fire[c]) void'(cq[c].pop_front());
            if (wrote) busy_left = busy_len;
            else if (busy_left > 0) busy_left--;
            drive_clients();
         end
      end
      if (check) begin
         vectors++;
         if (got_data.size() != exp_data.size()) begin
            miscompares++;
            $display("FAIL byte_count: got %0d writes, required %0d", got_data.size(), exp_data.size());
         end
         n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
         for (int i = 0; i < n; i++) begin
            vectors++;
            if (got_data[i] !== exp_data[i] || got_own[i] != exp_own[i]) begin
               miscompares++;
               $display("FAIL byte[%0d]: got %h from client %0d, required %h from client %0d",
                        i, got_data[i], got_own[i], exp_data[i], exp_own[i]);
            end
         end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      @(negedge clk);
      vectors += 3;
      if (bus.grant !== '0 || bus.req_ready !== '0) begin
         miscompares++;
         $display("FAIL reset_grant: grant=%b ready=%b, required 0", bus.grant, bus.req_ready);
      end
      if (bus.uart_write !== 1'b0 || bus.uart_data !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_uart: write=%b data=%h, required 0", bus.uart_write, bus.uart_data);
      end
      if (bus.timeout !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_timeout: got %b, required 0", bus.timeout);
      end
   endtask

   task automatic test_single_frame();
      apply_reset();
      busy_len = 10;
      cq[2].push_back(9'h041);
      cq[2].push_back(9'h142);
      run(300, 1'b1);
      vectors++;
      if (got_data.size() != 2) begin
         miscompares++;
         $display("FAIL single_count: got %0d writes, required 2", got_data.size());
      end else begin
         vectors += 2;
         if (got_data[0] !== 8'h41 || got_data[1] !== 8'h42) begin
            miscompares++;
            $display("FAIL single_data: got %h %h, required 41 42", got_data[0], got_data[1]);
         end
         if (got_cyc[1] - got_cyc[0] != 13) begin
            miscompares++;
            $display("FAIL single_spacing: got %0d cycles between writes, required 13", got_cyc[1] - got_cyc[0]);
         end
      end
      vectors++;
      if (gt_val.size() != 2 || gt_val[0] !== 4'b0100 || gt_val[1] !== 4'b0000 || gt_cyc[0] != 1) begin
         miscompares++;
         $display("FAIL single_grant: %0d grant changes, first=%b at cycle %0d, required 0100 at 1 then 0000",
                  gt_val.size(), (gt_val.size() > 0) ? gt_val[0] : 4'bx, (gt_cyc.size() > 0) ? gt_cyc[0] : -1);
      end
   endtask

   task automatic test_round_robin();
      int order_a [4] = '{0, 1, 2, 3};
      int order_b [4] = '{2, 3, 0, 1};
      apply_reset();
      busy_len = 4;
      for (int c = 0; c < NC; c++) cq[c].push_back(9'(9'h110 + c));
      run(400, 1'b1);
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (i >= got_own.size() || got_own[i] != order_a[i]) begin
            miscompares++;
            $display("FAIL rr_from_reset[%0d]: got client %0d, required %0d", i,
                     (i < got_own.size()) ? got_own[i] : -1, order_a[i]);
         end
      end
      cq[1].push_back(9'h155);
      run(200, 1'b1);
      for (int c = 0; c < NC; c++) cq[c].push_back(9'(9'h110 + c));
      run(400, 1'b1);
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (i >= got_own.size() || got_own[i] != order_b[i]) begin
            miscompares++;
            $display("FAIL rr_from_ptr2[%0d]: got client %0d, required %0d", i,
                     (i < got_own.size()) ? got_own[i] : -1, order_b[i]);
         end
      end
   endtask

   task automatic test_frame_lock();
      apply_reset();
      busy_len = int'($urandom_range(1, 5));
      cq[0].push_back({1'b0, 8'($urandom)});
      cq[0].push_back({1'b0, 8'($urandom)});
      cq[0].push_back({1'b1, 8'($urandom)});
      cq[1].push_back({1'b1, 8'($urandom)});
      run(500, 1'b1);
      vectors++;
      if (gt_val.size() < 3 || gt_val[0] !== 4'b0001 || gt_val[1] !== 4'b0000 ||
          gt_val[2] !== 4'b0010 || gt_cyc[2] - gt_cyc[1] != 1) begin
         miscompares++;
         $display("FAIL frame_lock: %0d grant changes, required 0001 -> 0000 -> 0010 one cycle apart",
                  gt_val.size());
      end
   endtask

   task automatic test_reset_mid_frame();
      apply_reset();
      busy_len = 20;
      cq[1].push_back(9'h0A1);
      cq[1].push_back(9'h1A2);
      run(8, 1'b0);
      vectors++;
      if (bus.grant !== 4'b0010 || bus.uart_data !== 8'hA1) begin
         miscompares++;
         $display("FAIL pre_reset: grant=%b data=%h, required 0010 A1", bus.grant, bus.uart_data);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (bus.grant !== '0 || bus.req_ready !== '0 || bus.uart_write !== 1'b0 ||
          bus.uart_data !== 8'h00 || bus.timeout !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: grant=%b ready=%b write=%b data=%h timeout=%b, required all 0",
                  bus.grant, bus.req_ready, bus.uart_write, bus.uart_data, bus.timeout);
      end
      cq[1].delete();
      cq[3].push_back(9'h133);
      busy_left = 1000;
      drive_clients();
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_ptr = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vectors++;
         if (bus.grant !== '0) begin
            miscompares++;
            $display("FAIL grant_while_busy[%0d]: got %b, required 0000", i, bus.grant);
         end
      end
      @(posedge clk);
      #1;
      busy_left = 0;
      busy_len  = 3;
      run(200, 1'b1);
      vectors++;
      if (gt_val.size() == 0 || gt_val[0] !== 4'b1000 || gt_cyc[0] != 1) begin
         miscompares++;
         $display("FAIL grant_after_busy: required 1000 one cycle after busy falls, got %0d changes",
                  gt_val.size());
      end
   endtask

   task automatic test_busy_never_rises();
      apply_reset();
      busy_len = 0;
      cq[0].push_back(9'h0B0);
      cq[0].push_back(9'h0B1);
      cq[0].push_back(9'h1B2);
      cq[2].push_back(9'h1C0);
      run(400, 1'b1);
      vectors++;
      if (got_cyc.size() < 2 || got_cyc[1] - got_cyc[0] != 5) begin
         miscompares++;
         $display("FAIL no_busy_spacing: got %0d writes, required 5-cycle spacing", got_cyc.size());
      end
   endtask

   task automatic test_random();
      int nf, nb;
      for (int it = 0; it < 12; it++) begin
         busy_len = int'($urandom_range(0, 6));
         for (int c = 0; c < NC; c++) begin
            nf = int'($urandom_range(0, 2));
            for (int f = 0; f < nf; f++) begin
               nb = int'($urandom_range(1, 3));
               for (int b = 0; b < nb; b++) cq[c].push_back({(b == nb - 1), 8'($urandom)});
            end
         end
         run(3000, 1'b1);
      end
   endtask

`ifdef UART_TX_ARB_TIMEOUT_EN
   task automatic test_timeout();
      apply_reset();
      busy_len = 2;
      cq[1].push_back(9'h0C1);
      cq[2].push_back(9'h1C2);
      run(300, 1'b0);
      vectors++;
      if (tmo_cyc.size() != 1 || got_cyc.size() == 0 || tmo_cyc[0] != got_cyc[0] + 20) begin
         miscompares++;
         $display("FAIL timeout_pulse: %0d pulses, required one pulse 16 cycles into SEND", tmo_cyc.size());
      end else begin
         vectors++;
         if (gt_val.size() < 3 || gt_cyc[1] != tmo_cyc[0] || gt_val[1] !== 4'b0000 ||
             gt_val[2] !== 4'b0100 || gt_cyc[2] != tmo_cyc[0] + 1) begin
            miscompares++;
            $display("FAIL timeout_regrant: required release with pulse, then 0100 one cycle later");
         end
      end
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      busy_left   = 0;
      busy_len    = 0;
      model_ptr   = 0;
      drive_clients();
      test_reset();
      test_single_frame();
      test_round_robin();
      test_frame_lock();
      test_reset_mid_frame();
      test_busy_never_rises();
      test_random();
`ifdef UART_TX_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
